r5p_soc_uart: RTL
=================

Name: r5p_soc_uart

Overview:
- Memory-mapped UART peripheral on a load/store bus decoder slave port, beside the GPIO controller.
- The core reaches it through its data bus.
- Provides one transmit holding register plus shift register, and one receive buffer with 8N1 framing.
- Has a programmable baud divisor and sticky error flags.

Parameters:
- AW, 4, bus address width. Only adr[3:2] is decoded.
- DW, 32, bus data width. Fixed at 32.
- DIV_RST, 16'd867, reset value of the baud divisor. Bit period is DIV+1 clocks.
- DIW, 16, baud divisor width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- bus_vld  input  1  transfer request
- bus_wen  input  1  write enable (1 = write)
- bus_adr  input  AW  byte address
- bus_ben  input  DW/8  byte enables. Writes apply only to enabled bytes.
- bus_wdt  input  DW  write data
- bus_rdt  output  DW  read data, registered
- bus_rdy  output  1  transfer accept
- uart_txd  output  1  serial transmit, idle high
- uart_rxd  input  1  serial receive, asynchronous

Behaviour:
- Register map (adr[3:2]):
  - 0 DATA: write loads TX holding[7:0]; read returns {24'h0, rx_buf} and clears rx_vld.
  - 1 STATUS: read returns {27'h0, tx_busy, frm_err, ovr_err, rx_vld, tx_rdy}. Write 1 to bit2/bit3 clears ovr_err/frm_err.
  - 2 DIV: read/write, DIW bits, zero-extended.
  - 3 reserved: reads 0, writes ignored.
- Handshake:
  - A transfer occurs when bus_vld & bus_rdy.
  - bus_rdy = 0 only for a DATA write while TX holding is full; otherwise bus_rdy = 1. The master holds the request until it is accepted.
  - Read data appears on bus_rdt the cycle after the transfer.
  - bus_rdt is held when no read is transferred.
- Reset values: bus_rdt = 0, uart_txd = 1, tx_rdy = 1, tx_busy = 0, rx_vld = 0, ovr_err = 0, frm_err = 0, DIV = DIV_RST, both FSMs idle.
- Reset mid-frame aborts the frame immediately. uart_txd returns to 1 the next cycle.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state/bit lasts DIV+1 clocks, counted by a down-counter reloaded with DIV.
  - IDLE with holding full: move holding to shifter, set tx_rdy = 1 the same cycle, tx_busy = 1, uart_txd = 0 on the next clock.
  - If holding is refilled during STOP, the next START follows STOP directly with no extra idle cycle.
  - tx_busy = 0 only in IDLE with holding empty.
- RX input: uart_rxd passes through a 2-flop synchronizer, with one extra flop for edge detect.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized falling edge loads the counter with DIV>>1 and enters START.
  - START: at count 0, if the line is 1 it is a glitch; return to IDLE, no flag. Otherwise reload DIV and enter DATA.
  - DATA: sample 8 bits at mid-bit, LSB first.
  - STOP: sample at mid-bit.
    - Sample 0: set frm_err and discard the byte.
    - Sample 1 with rx_vld already 1: set ovr_err and discard the new byte; rx_buf keeps the old byte.
    - Sample 1 otherwise: rx_buf = byte, rx_vld = 1.
    - Return to IDLE immediately after the sample, so a back-to-back start edge is detected.
- Simultaneous events:
  - Same-cycle DATA read and new byte completion: read returns the old byte, then rx_vld = 1 with the new byte; no overrun.
  - Same-cycle STATUS clear-write and error set: set wins.
- DIV write mid-frame takes effect at the next counter reload. DIV = 0 gives 1 clock per bit and must work.
- Partial-byte writes: DATA needs ben[0] to load; otherwise the write is ignored and tx holding is unchanged.

Test Plan:
- Reset, then read STATUS and DIV -> rdt = 0x0000_0001, then 0x0000_0363 (DIV_RST = 867).
- DIV = 3, write DATA 0x55 -> uart_txd sequence 0,1,0,1,0,1,0,1,0,1, each level 4 clocks, 40 clocks total, then idle 1. STATUS bit4 = 1 during the frame.
- DIV = 3, three back-to-back DATA writes 0xA1, 0xB2, 0xC3 -> first two accepted immediately. Third sees bus_rdy = 0 until the first frame's shifter loads the second byte. Frames are contiguous, 120 clocks total.
- DIV = 3, loop uart_txd to uart_rxd, send 0x3C -> STATUS = 0x03 after stop. DATA read = 0x3C. Next STATUS read = 0x01.
- Drive two RX frames 0x11, 0x22 without reading -> STATUS bit2 = 1, DATA reads 0x11. Write STATUS 0x4 -> bit2 = 0.
- Drive frame 0x7E with stop bit 0 -> frm_err = 1, rx_vld = 0.
- Drive a 1-clock low glitch on uart_rxd -> no flags, FSM back to IDLE.
- Assert rst mid-TX -> uart_txd = 1 next clock and all STATUS reset values restored.

Source files
------------

// File: rtl/r5p_soc_uart.sv
// Memory-mapped 8N1 UART: TX holding + shift register, single-entry RX buffer,
// programmable baud divisor (bit = DIV+1 clocks) and sticky overrun/framing flags.
module r5p_soc_uart #(
   parameter int unsigned    AW      = 4,
   parameter int unsigned    DW      = 32,
   parameter int unsigned    DIW     = 16,
   parameter logic [DIW-1:0] DIV_RST = 16'd867
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bus_vld,
   input  logic            bus_wen,
   input  logic [AW-1:0]   bus_adr,
   input  logic [DW/8-1:0] bus_ben,
   input  logic [DW-1:0]   bus_wdt,
   output logic [DW-1:0]   bus_rdt,
   output logic            bus_rdy,
   output logic            uart_txd,
   input  logic            uart_rxd
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_st_t;

   localparam logic [1:0]     REG_DATA = 2'd0;
   localparam logic [1:0]     REG_STAT = 2'd1;
   localparam logic [1:0]     REG_DIV  = 2'd2;
   localparam logic [DIW-1:0] CNT_ONE  = 1;

   logic [1:0]     reg_sel;
   logic           xfer, wr_en, rd_en;
   logic           wr_data, rd_data, wr_stat, wr_div;
   logic [DIW-1:0] div_mask;
   logic [DW-1:0]  rd_mux;
   logic [DW-1:0]  rdt_q, rdt_d;
   logic [DIW-1:0] div_q, div_d;

   uart_st_t       tx_state_q, tx_state_d;
   logic [DIW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]     tx_bit_q, tx_bit_d;
   logic [7:0]     tx_sh_q, tx_sh_d;
   logic [7:0]     tx_hold_q, tx_hold_d;
   logic           tx_full_q, tx_full_d;
   logic           txd_q, txd_d;
   logic           tx_load, tx_busy, tx_rdy;

   logic [2:0]     rx_sync_q, rx_sync_d;
   logic           rx_fall, rx_smp;
   uart_st_t       rx_state_q, rx_state_d;
   logic [DIW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]     rx_bit_q, rx_bit_d;
   logic [7:0]     rx_sh_q, rx_sh_d;
   logic [7:0]     rx_buf_q, rx_buf_d;
   logic           rx_vld_q, rx_vld_d;
   logic           ovr_q, ovr_d;
   logic           frm_q, frm_d;
   logic           rx_done;
   logic           unused_ok;

   assign reg_sel   = bus_adr[3:2];
   // The holding register frees up in the same cycle it is moved to the shifter.
   assign bus_rdy   = ~(bus_vld & bus_wen & (reg_sel == REG_DATA) & tx_full_q & ~tx_load);
   assign xfer      = bus_vld & bus_rdy;
   assign wr_en     = xfer & bus_wen;
   assign rd_en     = xfer & ~bus_wen;
   assign wr_data   = wr_en & (reg_sel == REG_DATA) & bus_ben[0];
   assign rd_data   = rd_en & (reg_sel == REG_DATA);
   assign wr_stat   = wr_en & (reg_sel == REG_STAT) & bus_ben[0];
   assign wr_div    = wr_en & (reg_sel == REG_DIV);
   assign unused_ok = ^{bus_adr, bus_wdt, bus_ben};

   always_comb begin
      div_mask = '0;
      for (int i = 0; i < DIW; i++) begin
         div_mask[i] = bus_ben[i/8];
      end
      div_d = div_q;
      if (wr_div) begin
         div_d = (div_q & ~div_mask) | (bus_wdt[DIW-1:0] & div_mask);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_DATA: rd_mux[7:0]     = rx_buf_q;
         REG_STAT: rd_mux[4:0]     = {tx_busy, frm_q, ovr_q, rx_vld_q, tx_rdy};
         REG_DIV:  rd_mux[DIW-1:0] = div_q;
         default:  rd_mux          = '0;
      endcase
      rdt_d = rd_en ? rd_mux : rdt_q;
   end

   // TX next-state
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_load    = 1'b0;
      case (tx_state_q)
         ST_IDLE: tx_load = tx_full_q;
         ST_START: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = ST_DATA;
               tx_cnt_d   = div_q;
               tx_bit_d   = '0;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         ST_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = div_q;
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = ST_STOP;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         default: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = ST_IDLE;
               tx_load    = tx_full_q;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
      endcase
      if (tx_load) begin
         tx_state_d = ST_START;
         tx_cnt_d   = div_q;
         tx_sh_d    = tx_hold_q;
      end
   end

   // TX outputs: line level is registered from the next state to stay glitch-free
   always_comb begin
      tx_hold_d = wr_data ? bus_wdt[7:0] : tx_hold_q;
      tx_full_d = tx_full_q;
      if (tx_load) begin
         tx_full_d = 1'b0;
      end
      if (wr_data) begin
         tx_full_d = 1'b1;
      end
      case (tx_state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = tx_sh_d[0];
         default:  txd_d = 1'b1;
      endcase
      tx_busy = (tx_state_q != ST_IDLE) | tx_full_q;
      tx_rdy  = ~tx_full_q;
   end

   // RX samples the delayed flop so that DIV = 0 still lands on the right bit.
   assign rx_sync_d = {rx_sync_q[1:0], uart_rxd};
   assign rx_fall   = rx_sync_q[2] & ~rx_sync_q[1];
   assign rx_smp    = rx_sync_q[2];

   // RX next-state
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_done    = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               rx_state_d = ST_START;
               rx_cnt_d   = div_q >> 1;
            end
         end
         ST_START: begin
            if (rx_cnt_q == '0) begin
               if (rx_smp) begin
                  rx_state_d = ST_IDLE;
               end else begin
                  rx_state_d = ST_DATA;
                  rx_cnt_d   = div_q;
                  rx_bit_d   = '0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_sh_d  = {rx_smp, rx_sh_q[7:1]};
               rx_cnt_d = div_q;
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = ST_STOP;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         default: begin
            if (rx_cnt_q == '0) begin
               rx_done    = 1'b1;
               rx_state_d = rx_fall ? ST_START : ST_IDLE;
               rx_cnt_d   = div_q >> 1;
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
      endcase
   end

   // RX outputs: clears are applied first so a same-cycle set wins
   always_comb begin
      rx_buf_d = rx_buf_q;
      rx_vld_d = rx_vld_q & ~rd_data;
      ovr_d    = ovr_q & ~(wr_stat & bus_wdt[2]);
      frm_d    = frm_q & ~(wr_stat & bus_wdt[3]);
      if (rx_done) begin
         if (!rx_smp) begin
            frm_d = 1'b1;
         end else if (rx_vld_q & ~rd_data) begin
            ovr_d = 1'b1;
         end else begin
            rx_buf_d = rx_sh_q;
            rx_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdt_q      <= '0;
         div_q      <= DIV_RST;
         tx_state_q <= ST_IDLE;
         tx_full_q  <= 1'b0;
         txd_q      <= 1'b1;
         rx_sync_q  <= '1;
         rx_state_q <= ST_IDLE;
         rx_vld_q   <= 1'b0;
         ovr_q      <= 1'b0;
         frm_q      <= 1'b0;
      end else begin
         rdt_q      <= rdt_d;
         div_q      <= div_d;
         tx_state_q <= tx_state_d;
         tx_full_q  <= tx_full_d;
         txd_q      <= txd_d;
         rx_sync_q  <= rx_sync_d;
         rx_state_q <= rx_state_d;
         rx_vld_q   <= rx_vld_d;
         ovr_q      <= ovr_d;
         frm_q      <= frm_d;
      end
   end

   always_ff @(posedge clk) begin
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_hold_q <= tx_hold_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_buf_q  <= rx_buf_d;
   end

   assign bus_rdt  = rdt_q;
   assign uart_txd = txd_q;

endmodule
